// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states,
// error codes, funct3 memory encodings and the registered bus payload.
package riscv_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [2:0] {
        LSU_ST_IDLE = 3'd0,
        LSU_ST_REQ  = 3'd1,
        LSU_ST_WAIT = 3'd2,
        LSU_ST_DONE = 3'd3,
        LSU_ST_ERR  = 3'd4
    } lsu_state_e;

    localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] LSU_ERR_FUNCT3   = 2'b11;

    localparam logic [2:0] FUNCT3_MEM_B  = 3'd0;
    localparam logic [2:0] FUNCT3_MEM_H  = 3'd1;
    localparam logic [2:0] FUNCT3_MEM_W  = 3'd2;
    localparam logic [2:0] FUNCT3_MEM_BU = 3'd4;
    localparam logic [2:0] FUNCT3_MEM_HU = 3'd5;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } lsu_bus_t;

    // Unsigned widths only make sense for loads.
    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            FUNCT3_MEM_B, FUNCT3_MEM_H, FUNCT3_MEM_W: return 1'b0;
            FUNCT3_MEM_BU, FUNCT3_MEM_HU:            return we;
            default:                                 return 1'b1;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            FUNCT3_MEM_H, FUNCT3_MEM_HU: return addr_lo[0];
            FUNCT3_MEM_W:                return addr_lo != 2'b00;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering for the LSU: store byte enables and data replication, and
// load data shift plus sign/zero extension. Purely combinational.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_wdata,
    output logic [BE_W-1:0] st_be_c,
    output logic [XLEN-1:0] st_wdata_c,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_rdata_c
);

    logic [XLEN-1:0] ld_shift;

    always_comb begin : store_path
        st_be_c    = 4'b1111;
        st_wdata_c = st_wdata;
        case (st_funct3)
            FUNCT3_MEM_B, FUNCT3_MEM_BU: begin
                st_be_c    = BE_W'(4'b0001 << st_addr_lo);
                st_wdata_c = {4{st_wdata[7:0]}};
            end
            FUNCT3_MEM_H, FUNCT3_MEM_HU: begin
                st_be_c    = BE_W'(4'b0011 << st_addr_lo);
                st_wdata_c = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin : load_path
        ld_shift   = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_rdata_c = ld_shift;
        case (ld_funct3)
            FUNCT3_MEM_B:  ld_rdata_c = {{24{ld_shift[7]}}, ld_shift[7:0]};
            FUNCT3_MEM_H:  ld_rdata_c = {{16{ld_shift[15]}}, ld_shift[15:0]};
            FUNCT3_MEM_BU: ld_rdata_c = {24'h000000, ld_shift[7:0]};
            FUNCT3_MEM_HU: ld_rdata_c = {16'h0000, ld_shift[15:0]};
            default:       ld_rdata_c = ld_shift;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: turns pipeline memory control into a registered
// req/gnt bus transaction, returns extended load data, stalls and reports errors.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wr_en,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_stall,
    output logic        o_lsu_done,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_err,
    output logic [1:0]  o_lsu_err_code,
    output logic        o_lsu_bus_req,
    output logic        o_lsu_bus_we,
    output logic [31:0] o_lsu_bus_addr,
    output logic [3:0]  o_lsu_bus_be,
    output logic [31:0] o_lsu_bus_wdata,
    input  logic        i_lsu_bus_gnt,
    input  logic        i_lsu_bus_rvalid,
    input  logic [31:0] i_lsu_bus_rdata
);

    localparam int unsigned     CNT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lsu_bus_t         bus_q, bus_d;
    logic             bus_req_q, bus_req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       funct3_q, funct3_d;

    logic [BE_W-1:0]  st_be_c;
    logic [XLEN-1:0]  st_wdata_c;
    logic [XLEN-1:0]  ld_rdata_c;
    logic             timeout_c;

    // Store lanes come from the live request; load lanes from the latched one.
    riscv_lsu_align u_align (
        .st_funct3  (i_lsu_funct3),
        .st_addr_lo (i_lsu_addr[1:0]),
        .st_wdata   (i_lsu_wdata),
        .st_be_c    (st_be_c),
        .st_wdata_c (st_wdata_c),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_lo_q),
        .ld_rdata   (i_lsu_bus_rdata),
        .ld_rdata_c (ld_rdata_c)
    );

    // Budget is shared across REQ and WAIT; a completion this cycle still wins.
    assign timeout_c = (cnt_q >= CNT_LAST);

    always_comb begin : next_state
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_d      = bus_q;
        bus_req_d  = bus_req_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        rdata_d    = rdata_q;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (i_lsu_valid) begin
                    if (funct3_illegal(i_lsu_funct3, i_lsu_wr_en)) begin
                        state_d    = LSU_ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = LSU_ERR_FUNCT3;
                    end else if (addr_misaligned(i_lsu_funct3, i_lsu_addr[1:0])) begin
                        state_d    = LSU_ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = LSU_ERR_MISALIGN;
                    end else begin
                        state_d     = LSU_ST_REQ;
                        bus_req_d   = 1'b1;
                        cnt_d       = '0;
                        bus_d.we    = i_lsu_wr_en;
                        bus_d.addr  = {i_lsu_addr[31:2], 2'b00};
                        bus_d.be    = st_be_c;
                        bus_d.wdata = st_wdata_c;
                        addr_lo_d   = i_lsu_addr[1:0];
                        funct3_d    = i_lsu_funct3;
                    end
                end
            end
            LSU_ST_REQ: begin
                if (i_lsu_bus_gnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (bus_q.we) begin
                        state_d = LSU_ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LSU_ST_WAIT;
                    end
                end else if (timeout_c) begin
                    state_d    = LSU_ST_ERR;
                    bus_req_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = LSU_ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_ST_WAIT: begin
                if (i_lsu_bus_rvalid) begin
                    state_d = LSU_ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = ld_rdata_c;
                end else if (timeout_c) begin
                    state_d    = LSU_ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = LSU_ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_ST_DONE, LSU_ST_ERR: state_d = LSU_ST_IDLE;
            default:                 state_d = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin : regs
        if (!i_rstn) begin
            state_q    <= LSU_ST_IDLE;
            cnt_q      <= '0;
            bus_q      <= '0;
            bus_req_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            rdata_q    <= '0;
            addr_lo_q  <= '0;
            funct3_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            bus_req_q  <= bus_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rdata_q    <= rdata_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
        end
    end

    assign o_lsu_stall = ((state_q == LSU_ST_IDLE) && i_lsu_valid)
                       || (state_q == LSU_ST_REQ) || (state_q == LSU_ST_WAIT);

    assign o_lsu_done      = done_q;
    assign o_lsu_err       = err_q;
    assign o_lsu_err_code  = err_code_q;
    assign o_lsu_rdata     = rdata_q;
    assign o_lsu_bus_req   = bus_req_q;
    assign o_lsu_bus_we    = bus_q.we;
    assign o_lsu_bus_addr  = bus_q.addr;
    assign o_lsu_bus_be    = bus_q.be;
    assign o_lsu_bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboarded bench for riscv_lsu: a bus responder backed by memory, a
// reference model pushing expected completions, and per-scenario timing checks.
`timescale 1ns/1ps
module tb_riscv_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid = 1'b0, lsu_wr_en = 1'b0;
    logic [2:0]  lsu_funct3 = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        o_lsu_stall, o_lsu_done, o_lsu_err, o_lsu_bus_req, o_lsu_bus_we;
    logic [31:0] o_lsu_rdata, o_lsu_bus_addr, o_lsu_bus_wdata;
    logic [1:0]  o_lsu_err_code;
    logic [3:0]  o_lsu_bus_be;

    riscv_lsu #(.BUS_TIMEOUT(TO)) u_dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_lsu_valid(lsu_valid), .i_lsu_wr_en(lsu_wr_en), .i_lsu_funct3(lsu_funct3),
        .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
        .o_lsu_stall(o_lsu_stall), .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
        .o_lsu_err(o_lsu_err), .o_lsu_err_code(o_lsu_err_code),
        .o_lsu_bus_req(o_lsu_bus_req), .o_lsu_bus_we(o_lsu_bus_we),
        .o_lsu_bus_addr(o_lsu_bus_addr), .o_lsu_bus_be(o_lsu_bus_be),
        .o_lsu_bus_wdata(o_lsu_bus_wdata),
        .i_lsu_bus_gnt(bus_gnt), .i_lsu_bus_rvalid(bus_rvalid), .i_lsu_bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [1:0]  code;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] mem_bus [logic [31:0]];
    logic [31:0] mem_ref [logic [31:0]];
    logic [31:0] rdata_ref = '0;
    int          total = 0, bad = 0;

    // Reference model: expected outcome of one access, pushed at issue time.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input bit to);
        exp_t        e;
        logic [31:0] wa, w, s;
        int          sh;
        wa = {a[31:2], 2'b00};
        sh = 8 * int'(a[1:0]);
        w  = mem_ref.exists(wa) ? mem_ref[wa] : 32'h0;
        e.err = 1'b0; e.code = 2'b00; e.rdata = rdata_ref;
        if (f3 == 3 || f3 == 6 || f3 == 7 || (we && (f3 == 4 || f3 == 5))) begin
            e.err = 1'b1; e.code = 2'b11;
        end else if (((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 2'b00)) begin
            e.err = 1'b1; e.code = 2'b01;
        end else if (to) begin
            e.err = 1'b1; e.code = 2'b10;
        end else if (we) begin
            if (f3 == 0)      w[sh +: 8]  = wd[7:0];
            else if (f3 == 1) w[sh +: 16] = wd[15:0];
            else              w = wd;
            mem_ref[wa] = w;
        end else begin
            s = w >> sh;
            case (f3)
                3'd0:    e.rdata = {{24{s[7]}}, s[7:0]};
                3'd1:    e.rdata = {{16{s[15]}}, s[15:0]};
                3'd4:    e.rdata = {24'h0, s[7:0]};
                3'd5:    e.rdata = {16'h0, s[15:0]};
                default: e.rdata = s;
            endcase
            rdata_ref = e.rdata;
        end
        sb_q.push_back(e);
    endtask

    // Scoreboard: every done/err pulse consumes one expected completion.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (o_lsu_done === 1'b1 || o_lsu_err === 1'b1)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: done=%0b err=%0b with nothing pending", o_lsu_done, o_lsu_err);
            end else begin
                sb_e = sb_q.pop_front();
                if (o_lsu_done !== !sb_e.err || o_lsu_err !== sb_e.err ||
                    (sb_e.err && o_lsu_err_code !== sb_e.code) || o_lsu_rdata !== sb_e.rdata) begin
                    bad++;
                    $display("FAIL sb_result: got done=%0b err=%0b code=%b rdata=%h want err=%0b code=%b rdata=%h",
                             o_lsu_done, o_lsu_err, o_lsu_err_code, o_lsu_rdata, sb_e.err, sb_e.code, sb_e.rdata);
                end
            end
        end
    end

    // Drives one access and plays the bus; returns at the negedge of the done/err cycle.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int gdly, input int rdly, input bit exp_to,
                             output int lat, output bit stall_ok, output bit req_seen, output bit req_end,
                             output logic [31:0] b_addr, output logic [3:0] b_be, output logic [31:0] b_wdata);
        int          req_cnt, wait_cnt;
        bit          waiting;
        logic [31:0] wv;
        lat = -1; stall_ok = 1'b1; req_seen = 1'b0; req_end = 1'b0;
        b_addr = '0; b_be = '0; b_wdata = '0;
        req_cnt = 0; wait_cnt = 0; waiting = 1'b0;
        @(negedge clk);
        lsu_valid = 1'b1; lsu_wr_en = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        model_push(we, f3, a, wd, exp_to);
        #1;
        if (o_lsu_stall !== 1'b1) stall_ok = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (o_lsu_done === 1'b1 || o_lsu_err === 1'b1) begin
                lat = k;
                req_end = o_lsu_bus_req;
                if (o_lsu_stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (o_lsu_stall !== 1'b1) stall_ok = 1'b0;
            if (waiting) begin
                if (wait_cnt == rdly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = mem_bus.exists(b_addr) ? mem_bus[b_addr] : 32'h0;
                    waiting    = 1'b0;
                end
                wait_cnt++;
            end
            if (o_lsu_bus_req === 1'b1) begin
                if (!req_seen) begin
                    b_addr = o_lsu_bus_addr; b_be = o_lsu_bus_be; b_wdata = o_lsu_bus_wdata;
                end
                req_seen = 1'b1;
                if (req_cnt == gdly) begin
                    bus_gnt = 1'b1;
                    if (o_lsu_bus_we) begin
                        wv = mem_bus.exists(o_lsu_bus_addr) ? mem_bus[o_lsu_bus_addr] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (o_lsu_bus_be[b]) wv[8*b +: 8] = o_lsu_bus_wdata[8*b +: 8];
                        mem_bus[o_lsu_bus_addr] = wv;
                    end else begin
                        waiting = 1'b1; wait_cnt = 0;
                    end
                end
                req_cnt++;
            end
        end
        lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({o_lsu_bus_req, o_lsu_bus_we, o_lsu_bus_addr, o_lsu_bus_be, o_lsu_bus_wdata} !== '0) begin
            bad++; $display("FAIL rst_bus: req=%b addr=%h be=%b wdata=%h want all 0",
                            o_lsu_bus_req, o_lsu_bus_addr, o_lsu_bus_be, o_lsu_bus_wdata);
        end
        total++;
        if ({o_lsu_done, o_lsu_err, o_lsu_err_code, o_lsu_rdata, o_lsu_stall} !== '0) begin
            bad++; $display("FAIL rst_out: done=%b err=%b code=%b rdata=%h stall=%b want all 0",
                            o_lsu_done, o_lsu_err, o_lsu_err_code, o_lsu_rdata, o_lsu_stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        int lat; bit sok, rs, re; logic [31:0] ba, bw; logic [3:0] be;
        do_access(1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 2) begin bad++; $display("FAIL sb_latency: got %0d want 2", lat); end
        total++; if (be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", be); end
        total++; if (bw !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata: got %h want ababab ab", bw); end
        total++; if (ba !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr: got %h want 00001000", ba); end
        total++; if (!sok || re) begin bad++; $display("FAIL sb_stall: stall_ok=%0b req_at_done=%0b want 1/0", sok, re); end
    endtask

    task automatic test_load_half();
        int lat; bit sok, rs, re; logic [31:0] ba, bw; logic [3:0] be;
        mem_bus[32'h2000] = 32'h8001_1234;
        mem_ref[32'h2000] = 32'h8001_1234;
        do_access(1'b0, 3'd1, 32'h2002, 32'h0, 0, 2, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (o_lsu_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_rdata: got %h want ffff8001", o_lsu_rdata); end
        total++; if (lat != 5 || !sok) begin bad++; $display("FAIL lh_timing: lat=%0d stall_ok=%0b want 5/1", lat, sok); end
        do_access(1'b0, 3'd5, 32'h2002, 32'h0, 0, 2, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (o_lsu_rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_rdata: got %h want 00008001", o_lsu_rdata); end
        do_access(1'b0, 3'd2, 32'h2000, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 3 || !sok) begin bad++; $display("FAIL lw_zero_wait: lat=%0d stall_ok=%0b want 3/1", lat, sok); end
        total++; if (o_lsu_rdata !== 32'h8001_1234) begin bad++; $display("FAIL lw_rdata: got %h want 80011234", o_lsu_rdata); end
    endtask

    task automatic test_errors();
        int lat; bit sok, rs, re; logic [31:0] ba, bw; logic [3:0] be;
        do_access(1'b0, 3'd2, 32'h3001, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 1 || rs || !sok) begin bad++; $display("FAIL lw_misalign: lat=%0d req_seen=%0b stall_ok=%0b want 1/0/1", lat, rs, sok); end
        total++; if (o_lsu_err_code !== 2'b01) begin bad++; $display("FAIL lw_misalign_code: got %b want 01", o_lsu_err_code); end
        do_access(1'b0, 3'd3, 32'h3000, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 1 || rs || o_lsu_err_code !== 2'b11) begin bad++; $display("FAIL f3_illegal: lat=%0d req_seen=%0b code=%b want 1/0/11", lat, rs, o_lsu_err_code); end
        do_access(1'b1, 3'd5, 32'h3000, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 1 || o_lsu_err_code !== 2'b11) begin bad++; $display("FAIL store_hu: lat=%0d code=%b want 1/11", lat, o_lsu_err_code); end
        do_access(1'b1, 3'd1, 32'h3003, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 1 || rs || o_lsu_err_code !== 2'b01) begin bad++; $display("FAIL sh_misalign: lat=%0d req_seen=%0b code=%b want 1/0/01", lat, rs, o_lsu_err_code); end
    endtask

    task automatic test_timeout();
        int lat; bit sok, rs, re; logic [31:0] ba, bw; logic [3:0] be;
        do_access(1'b1, 3'd2, 32'h5000, 32'h1111_2222, 100, 0, 1'b1, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 5 || re || o_lsu_err_code !== 2'b10) begin bad++; $display("FAIL to_req: lat=%0d req_at_err=%0b code=%b want 5/0/10", lat, re, o_lsu_err_code); end
        do_access(1'b1, 3'd2, 32'h5000, 32'h3333_4444, 3, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 5 || o_lsu_done !== 1'b1) begin bad++; $display("FAIL to_last_gnt: lat=%0d done=%b want 5/1", lat, o_lsu_done); end
        do_access(1'b0, 3'd2, 32'h5000, 32'h0, 0, 5, 1'b1, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 5 || o_lsu_err_code !== 2'b10) begin bad++; $display("FAIL to_wait: lat=%0d code=%b want 5/10", lat, o_lsu_err_code); end
    endtask

    task automatic test_reset_mid();
        int lat; bit sok, rs, re, stray; logic [31:0] ba, bw; logic [3:0] be;
        mem_bus[32'h6000] = 32'h1122_3344;
        mem_ref[32'h6000] = 32'h1122_3344;
        @(negedge clk);
        lsu_valid = 1'b1; lsu_wr_en = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h6000;
        @(negedge clk);
        bus_gnt = o_lsu_bus_req;
        @(negedge clk);
        bus_gnt = 1'b0;
        rst_n = 1'b0; lsu_valid = 1'b0;
        rdata_ref = '0;
        #1;
        total++;
        if ({o_lsu_bus_req, o_lsu_bus_be, o_lsu_bus_addr, o_lsu_bus_wdata, o_lsu_rdata,
             o_lsu_done, o_lsu_err, o_lsu_err_code, o_lsu_stall} !== '0) begin
            bad++; $display("FAIL rst_async: req=%b be=%b addr=%h rdata=%h stall=%b want all 0",
                            o_lsu_bus_req, o_lsu_bus_be, o_lsu_bus_addr, o_lsu_rdata, o_lsu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (o_lsu_done !== 1'b0 || o_lsu_rdata !== 32'h0) stray = 1'b1;
        end
        total++; if (stray) begin bad++; $display("FAIL rst_stray_rvalid: done or rdata changed after reset, rdata=%h want 0", o_lsu_rdata); end
        do_access(1'b0, 3'd2, 32'h6000, 32'h0, 0, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
        total++; if (lat != 3 || o_lsu_rdata !== 32'h1122_3344) begin bad++; $display("FAIL rst_next: lat=%0d rdata=%h want 3/11223344", lat, o_lsu_rdata); end
    endtask

    task automatic test_back_to_back();
        int lat, gd, rd; bit sok, rs, re; logic [31:0] ba, bw, wa; logic [3:0] be;
        for (int i = 0; i < 10; i++) begin
            wa = 32'h4000 + 32'(4 * $urandom_range(0, 7));
            gd = $urandom_range(0, 3);
            do_access(1'b1, 3'd2, wa, $urandom, gd, 0, 1'b0, lat, sok, rs, re, ba, be, bw);
            total++; if (lat != 2 + gd || !sok) begin bad++; $display("FAIL b2b_sw[%0d]: lat=%0d stall_ok=%0b want %0d/1", i, lat, sok, 2 + gd); end
            gd = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            do_access(1'b0, 3'd4, wa + 32'($urandom_range(0, 3)), 32'h0, gd, rd, 1'b0, lat, sok, rs, re, ba, be, bw);
            total++; if (lat != 3 + gd + rd || !sok) begin bad++; $display("FAIL b2b_lbu[%0d]: lat=%0d stall_ok=%0b want %0d/1", i, lat, sok, 3 + gd + rd); end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_drain: %0d completions missing, want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the pipelined RV32I core, sitting in the MEM stage between the pipeline control outputs and the data-memory bus. It converts the pipeline's memory control (write enable, load flag, funct3, address, store data) into a registered request/grant bus transaction. It returns aligned, sign- or zero-extended load data. It stalls the pipeline while a transaction is outstanding and reports misaligned, illegal-width and bus-timeout errors.

## Interface
- `BUS_TIMEOUT`, default 255: number of cycles allowed in REQ+WAIT before the timeout error fires (≥2).
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_lsu_valid`  in  1  MEM-stage instruction is a load or a store; held stable while `o_lsu_stall`=1.
- `i_lsu_wr_en`  in  1  1=store, 0=load.
- `i_lsu_funct3`  in  3  access width/sign (0 B, 1 H, 2 W, 4 BU, 5 HU).
- `i_lsu_addr`  in  32  byte address from ALU.
- `i_lsu_wdata`  in  32  store data (rs2).
- `o_lsu_stall`  out  1  freeze IF/ID/EX/MEM.
- `o_lsu_done`  out  1  one-cycle pulse: access completed.
- `o_lsu_rdata`  out  32  extended load data, valid with `o_lsu_done` on loads.
- `o_lsu_err`  out  1  one-cycle pulse: access aborted.
- `o_lsu_err_code`  out  2  01 misaligned, 10 timeout, 11 illegal funct3.
- `o_lsu_bus_req`  out  1  bus request, registered.
- `o_lsu_bus_we`  out  1  bus write.
- `o_lsu_bus_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `o_lsu_bus_be`  out  4  byte-lane enables.
- `o_lsu_bus_wdata`  out  32  lane-replicated store data.
- `i_lsu_bus_gnt`  in  1  request accepted this cycle.
- `i_lsu_bus_rvalid`  in  1  read data valid; never earlier than the cycle after gnt.
- `i_lsu_bus_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE with `i_lsu_valid`:
  - illegal funct3 (3, 6, 7; or 4/5 on store) → ERR, code 11.
  - else misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0) → ERR, code 01.
  - else → REQ; latch addr[1:0], funct3, we; drive bus outputs registered.
- Byte enables: B/BU `0001<<addr[1:0]`; H/HU `0011<<addr[1:0]`; W `1111`.
- Store data replication: B `{4{wdata[7:0]}}`; H `{2{wdata[15:0]}}`; W as-is.
- REQ: hold `bus_req`=1 and all bus fields stable until `i_lsu_bus_gnt`=1. Then clear `bus_req`; store → DONE, load → WAIT.
- WAIT: on `i_lsu_bus_rvalid` shift rdata right by 8·addr[1:0], extend per funct3 (B/H sign, BU/HU zero), register into `o_lsu_rdata`, → DONE. `rvalid` outside WAIT is ignored.
- Timeout counter: cleared on IDLE→REQ, increments each cycle in REQ/WAIT. If it reaches `BUS_TIMEOUT` without a completing gnt/rvalid → ERR, code 10, `bus_req` dropped. A completion in the same cycle wins.
- DONE: `o_lsu_done`=1, stall=0 → IDLE. ERR: `o_lsu_err`=1, stall=0 → IDLE.
- `o_lsu_stall` = (IDLE & valid) | REQ | WAIT; combinational from state and `i_lsu_valid`.
- `o_lsu_rdata` holds its last value until the next load completes; it is 0 for stores' DONE? No: it is unchanged on stores.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (`bus_req`, `be`, `addr`, `wdata`, `rdata`, `done`, `err`, `err_code`). Reset mid-transaction drops `bus_req` immediately; no completion pulse follows.
- Zero-wait store: accept cycle C; `bus_req` at C+1 with gnt; `done` at C+2. Stall asserted C..C+1.
- Zero-wait load: gnt at C+1, rvalid at C+2, `done`/`rdata` at C+3. Stall asserted C..C+2.
- Misaligned or illegal access: stall at C only, `err` at C+1, no bus activity.
- Back-to-back: a new request is seen in the IDLE cycle after DONE/ERR.

## Structure
- Add to `riscv_configs.v`:
  - `LSU_ST_*` state encodings.
  - `LSU_ERR_*` codes.
  - reuse existing `FUNCT3_MEM_*`.
- Sub-module `riscv_lsu_align`: combinational byte-enable generation, store replication, load shift/extend. It is instantiated once for the store path and once for the load path, or a single instance with split ports.

## Test plan
- `sb` addr 0x1003, wdata 0xAB, gnt immediately → be 1000, bus_wdata 0xABABABAB, bus_addr 0x1000, done at C+2.
- `lh` addr 0x2002, rdata 0x8001_1234 after 3 wait cycles → `o_lsu_rdata`=0xFFFF8001; `lhu` same → 0x00008001; stall for the whole transaction.
- `lw` addr 0x3001 → err code 01 at C+1, `bus_req` never asserted; `lb` funct3=3 → err code 11.
- gnt withheld, `BUS_TIMEOUT`=4 → err code 10 exactly 4 cycles after REQ entry, `bus_req` low after. Gnt arriving on the 4th cycle → normal completion, no error.
- Reset asserted in WAIT → all outputs 0 asynchronously; a later rvalid is ignored; the next request proceeds normally.
- Back-to-back `sw`/`lbu` with random gnt/rvalid delays → per-access done pulses and correct data against a reference memory model.
